// File: rtl/dht_rx_ctrl.sv
`timescale 1ns/1ps
// dht_rx_ctrl: single-wire humidity/temperature sensor controller.
// Issues the host start pulse on an open-drain pad, times every phase with a
// microsecond prescaler, decodes the 40-bit frame (DHT11 or DHT22 layout),
// verifies the checksum, and publishes scaled readings with TH/TL alarms
// that use hysteresis.
module dht_rx_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int MODE       = 0,
    parameter int START_US   = 18000,
    parameter int BIT_THR_US = 40,
    parameter int TIMEOUT_US = 200,
    parameter int T_HI       = 300,
    parameter int T_LO       = 100,
    parameter int HYST       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dht_i,
    output logic        dht_oe,
    output logic        busy,
    output logic [39:0] frame,
    output logic [15:0] hum_x10,
    output logic [15:0] temp_x10,
    output logic        valid,
    output logic        err_cksum,
    output logic        err_timeout,
    output logic        TH,
    output logic        TL
);

    // Cycles per microsecond tick, never below one.
    localparam int US_DIV_RAW = CLK_HZ / 32'sd1_000_000;
    localparam int US_DIV     = (US_DIV_RAW < 32'sd1) ? 32'sd1 : US_DIV_RAW;
    localparam int PRE_W      = (US_DIV > 32'sd1) ? $clog2(US_DIV) : 32'sd1;

    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(US_DIV - 32'sd1);

    localparam logic [31:0] START_CNT = 32'(START_US);
    localparam logic [31:0] THR_CNT   = 32'(BIT_THR_US);
    localparam logic [31:0] TO_CNT    = 32'(TIMEOUT_US);
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    // Alarm thresholds as signed tenths of a degree.
    localparam logic signed [15:0] TH_SET = 16'(T_HI);
    localparam logic signed [15:0] TH_CLR = 16'(T_HI - HYST);
    localparam logic signed [15:0] TL_SET = 16'(T_LO);
    localparam logic signed [15:0] TL_CLR = 16'(T_LO + HYST);

    localparam logic [5:0] LAST_BIT = 6'd39;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_LOW = 4'd1,
        ST_RELEASE   = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_CHECK     = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    // Modulo-256 sum of the four data bytes of a frame.
    function automatic logic [7:0] frame_sum(input logic [39:0] f);
        frame_sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

    // Humidity in tenths of a percent for the selected frame layout.
    function automatic logic [15:0] hum_scale(input logic [39:0] f);
        if (MODE == 0) begin
            hum_scale = ({8'd0, f[39:32]} * 16'd10) + {8'd0, f[31:24]};
        end else begin
            hum_scale = f[39:24];
        end
    endfunction

    // Temperature in tenths of a degree; the DHT22 layout is sign-magnitude.
    function automatic logic [15:0] temp_scale(input logic [39:0] f);
        logic [15:0] mag;
        if (MODE == 0) begin
            mag        = 16'd0;
            temp_scale = ({8'd0, f[23:16]} * 16'd10) + {12'd0, f[11:8]};
        end else begin
            mag = {1'b0, f[22:8]};
            if (f[23]) begin
                temp_scale = 16'd0 - mag;
            end else begin
                temp_scale = mag;
            end
        end
    endfunction

    state_t              state_r;
    logic [PRE_W-1:0]    pre_r;
    logic [31:0]         cnt_r;
    logic [5:0]          bit_idx_r;
    logic [39:0]         sh_r;
    logic                sync1_r;
    logic                sync2_r;
    logic                sync3_r;
    logic                oe_r;
    logic                busy_r;
    logic [39:0]         frame_r;
    logic [15:0]         hum_r;
    logic [15:0]         temp_r;
    logic                valid_r;
    logic                err_ck_r;
    logic                err_to_r;
    logic                th_r;
    logic                tl_r;

    logic                tick_s;
    logic [31:0]         cnt_inc_s;
    logic                rise_s;
    logic                fall_s;
    logic                timeout_s;
    logic                bit_s;
    logic                cksum_ok_s;
    logic [15:0]         hum_new_s;
    logic signed [15:0]  temp_new_s;

    // Two-flop synchroniser on the pad plus one history flop for edge detection;
    // the line idles high, so the flops reset high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            sync3_r <= 1'b1;
        end else begin
            sync1_r <= dht_i;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Microsecond tick, phase count including the current cycle, line edges
    // and the readings decoded from the shift register.
    always_comb begin
        tick_s = (pre_r == PRE_LAST);
        if (tick_s && (cnt_r != CNT_MAX)) begin
            cnt_inc_s = cnt_r + 32'd1;
        end else begin
            cnt_inc_s = cnt_r;
        end
        rise_s     = sync2_r & ~sync3_r;
        fall_s     = ~sync2_r & sync3_r;
        timeout_s  = (cnt_inc_s >= TO_CNT);
        bit_s      = (cnt_inc_s > THR_CNT);
        cksum_ok_s = (frame_sum(sh_r) == sh_r[7:0]);
        hum_new_s  = hum_scale(sh_r);
        temp_new_s = temp_scale(sh_r);
    end

    // Protocol state machine with prescaler, phase counter, bit shifter and
    // all registered outputs; every state change restarts phase timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pre_r     <= PRE_ZERO;
            cnt_r     <= 32'd0;
            bit_idx_r <= 6'd0;
            sh_r      <= 40'd0;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            frame_r   <= 40'd0;
            hum_r     <= 16'd0;
            temp_r    <= 16'd0;
            valid_r   <= 1'b0;
            err_ck_r  <= 1'b0;
            err_to_r  <= 1'b0;
            th_r      <= 1'b0;
            tl_r      <= 1'b0;
        end else begin
            valid_r  <= 1'b0;
            err_ck_r <= 1'b0;
            err_to_r <= 1'b0;
            cnt_r    <= cnt_inc_s;
            if (tick_s) begin
                pre_r <= PRE_ZERO;
            end else begin
                pre_r <= pre_r + PRE_ONE;
            end

            case (state_r)
                ST_IDLE: begin
                    oe_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_START_LOW;
                        busy_r  <= 1'b1;
                        oe_r    <= 1'b1;
                        pre_r   <= PRE_ZERO;
                        cnt_r   <= 32'd0;
                    end
                end
                ST_START_LOW: begin
                    if (cnt_inc_s >= START_CNT) begin
                        state_r <= ST_RELEASE;
                        oe_r    <= 1'b0;
                        pre_r   <= PRE_ZERO;
                        cnt_r   <= 32'd0;
                    end
                end
                ST_RELEASE, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH: begin
                    oe_r <= 1'b0;
                    if ((state_r == ST_RELEASE) && fall_s) begin
                        state_r <= ST_RESP_LOW;
                        pre_r   <= PRE_ZERO;
                        cnt_r   <= 32'd0;
                    end else if ((state_r == ST_RESP_LOW) && rise_s) begin
                        state_r <= ST_RESP_HIGH;
                        pre_r   <= PRE_ZERO;
                        cnt_r   <= 32'd0;
                    end else if ((state_r == ST_RESP_HIGH) && fall_s) begin
                        state_r   <= ST_BIT_LOW;
                        bit_idx_r <= 6'd0;
                        pre_r     <= PRE_ZERO;
                        cnt_r     <= 32'd0;
                    end else if ((state_r == ST_BIT_LOW) && rise_s) begin
                        state_r <= ST_BIT_HIGH;
                        pre_r   <= PRE_ZERO;
                        cnt_r   <= 32'd0;
                    end else if ((state_r == ST_BIT_HIGH) && fall_s) begin
                        sh_r      <= {sh_r[38:0], bit_s};
                        bit_idx_r <= bit_idx_r + 6'd1;
                        pre_r     <= PRE_ZERO;
                        cnt_r     <= 32'd0;
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= ST_CHECK;
                        end else begin
                            state_r <= ST_BIT_LOW;
                        end
                    end else if (timeout_s) begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        err_to_r <= 1'b1;
                        pre_r    <= PRE_ZERO;
                        cnt_r    <= 32'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CHECK: begin
                    state_r <= ST_DONE;
                    pre_r   <= PRE_ZERO;
                    cnt_r   <= 32'd0;
                    if (cksum_ok_s) begin
                        frame_r <= sh_r;
                        hum_r   <= hum_new_s;
                        temp_r  <= temp_new_s;
                        valid_r <= 1'b1;
                        // High alarm: set at/above T_HI, clear below T_HI-HYST.
                        if (temp_new_s >= TH_SET) begin
                            th_r <= 1'b1;
                        end else if (temp_new_s < TH_CLR) begin
                            th_r <= 1'b0;
                        end else begin
                            th_r <= th_r;
                        end
                        // Low alarm: set at/below T_LO, clear above T_LO+HYST.
                        if (temp_new_s <= TL_SET) begin
                            tl_r <= 1'b1;
                        end else if (temp_new_s > TL_CLR) begin
                            tl_r <= 1'b0;
                        end else begin
                            tl_r <= tl_r;
                        end
                    end else begin
                        err_ck_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    pre_r   <= PRE_ZERO;
                    cnt_r   <= 32'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    oe_r    <= 1'b0;
                    pre_r   <= PRE_ZERO;
                    cnt_r   <= 32'd0;
                end
            endcase
        end
    end

    assign dht_oe      = oe_r;
    assign busy        = busy_r;
    assign frame       = frame_r;
    assign hum_x10     = hum_r;
    assign temp_x10    = temp_r;
    assign valid       = valid_r;
    assign err_cksum   = err_ck_r;
    assign err_timeout = err_to_r;
    assign TH          = th_r;
    assign TL          = tl_r;

endmodule

// File: tb/tb_dht_rx_ctrl.sv
`timescale 1ns/1ps
// Bench for dht_rx_ctrl: one DHT11-format and one DHT22-format instance,
// each driven by a behavioural open-drain sensor. Expected events are queued
// when a transaction starts and compared when the controller reports.
module tb_dht_rx_ctrl;

    localparam int START_US = 20;

    localparam logic [1:0] K_VALID   = 2'd0;
    localparam logic [1:0] K_CKSUM   = 2'd1;
    localparam logic [1:0] K_TIMEOUT = 2'd2;
    localparam logic [1:0] K_NONE    = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [39:0] frame;
        logic [15:0] hum;
        logic [15:0] temp;
        logic        th;
        logic        tl;
    } exp_t;

    typedef struct {
        int          d;
        logic [39:0] data;
        int          h0;
        int          h1;
        int          nbits;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        start  [2];
    logic        sens   [2];
    logic        line   [2];
    logic        oe     [2];
    logic        busy   [2];
    logic [39:0] frame  [2];
    logic [15:0] hum    [2];
    logic [15:0] temp   [2];
    logic        valid  [2];
    logic        err_c  [2];
    logic        err_t  [2];
    logic        th     [2];
    logic        tl     [2];

    int n_checks = 0;
    int n_errors = 0;
    int last_rise = 0;
    int evt_cyc [2];
    exp_t q0[$];
    exp_t q1[$];
    vec_t vecs [10];

    assign line[0] = ~oe[0] & sens[0];
    assign line[1] = ~oe[1] & sens[1];

    dht_rx_ctrl #(.CLK_HZ(1_000_000), .MODE(0), .START_US(START_US)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .dht_i(line[0]),
        .dht_oe(oe[0]), .busy(busy[0]), .frame(frame[0]), .hum_x10(hum[0]),
        .temp_x10(temp[0]), .valid(valid[0]), .err_cksum(err_c[0]),
        .err_timeout(err_t[0]), .TH(th[0]), .TL(tl[0])
    );

    dht_rx_ctrl #(.CLK_HZ(1_000_000), .MODE(1), .START_US(START_US)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .dht_i(line[1]),
        .dht_oe(oe[1]), .busy(busy[1]), .frame(frame[1]), .hum_x10(hum[1]),
        .temp_x10(temp[1]), .valid(valid[1]), .err_cksum(err_c[1]),
        .err_timeout(err_t[1]), .TH(th[1]), .TL(tl[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk($sformatf("%s_d%0d_oe", tag, d), oe[d], 0);
        chk($sformatf("%s_d%0d_busy", tag, d), busy[d], 0);
        chk($sformatf("%s_d%0d_frame", tag, d), frame[d], 0);
        chk($sformatf("%s_d%0d_hum", tag, d), hum[d], 0);
        chk($sformatf("%s_d%0d_temp", tag, d), temp[d], 0);
        chk($sformatf("%s_d%0d_valid", tag, d), valid[d], 0);
        chk($sformatf("%s_d%0d_errc", tag, d), err_c[d], 0);
        chk($sformatf("%s_d%0d_errt", tag, d), err_t[d], 0);
        chk($sformatf("%s_d%0d_th", tag, d), th[d], 0);
        chk($sformatf("%s_d%0d_tl", tag, d), tl[d], 0);
    endtask

    function automatic vec_t mk(input int d, input logic [39:0] data, input int h0,
                                input int h1, input int nbits, input logic [1:0] kind,
                                input logic [39:0] fr, input logic [15:0] h,
                                input logic [15:0] t, input logic a_th, input logic a_tl);
        vec_t v;
        v.d = d; v.data = data; v.h0 = h0; v.h1 = h1; v.nbits = nbits;
        v.e.kind = kind; v.e.frame = fr; v.e.hum = h; v.e.temp = t;
        v.e.th = a_th; v.e.tl = a_tl;
        return v;
    endfunction

    // Host start, then the sensor's response and nbits data bits (MSB first),
    // a closing low and release. Line stays high afterwards.
    task automatic send_frame(input int d, input logic [39:0] data, input int h0,
                              input int h1, input int nbits);
        int n;
        start[d] = 1'b1;
        wait_cyc(1);
        start[d] = 1'b0;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (oe[d]) n++;
            else if (n > 0) break;
        end
        chk($sformatf("d%0d_start_low_len", d), n, START_US);
        chk($sformatf("d%0d_busy_during", d), busy[d], 1);
        wait_cyc(30);
        sens[d] = 1'b0; wait_cyc(80);
        sens[d] = 1'b1; wait_cyc(80);
        for (int i = 0; i < nbits; i++) begin
            sens[d] = 1'b0; wait_cyc(50);
            sens[d] = 1'b1; last_rise = cyc;
            wait_cyc(data[39-i] ? h1 : h0);
        end
        sens[d] = 1'b0; wait_cyc(50);
        sens[d] = 1'b1; last_rise = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        int qn;
        int lat;
        if (v.d == 0) q0.push_back(v.e);
        else q1.push_back(v.e);
        send_frame(v.d, v.data, v.h0, v.h1, v.nbits);
        qn = 1;
        for (int k = 0; k < 300; k++) begin
            qn = (v.d == 0) ? q0.size() : q1.size();
            if (qn == 0) break;
            wait_cyc(1);
        end
        chk($sformatf("d%0d_event_seen", v.d), qn, 0);
        if (v.e.kind == K_TIMEOUT) begin
            lat = evt_cyc[v.d] - last_rise;
            n_checks++;
            if (lat < 200 || lat > 206) begin
                n_errors++;
                $display("FAIL d%0d_timeout_latency: got %0d want 200..206", v.d, lat);
            end
        end
        wait_cyc(3);
        chk($sformatf("d%0d_busy_after", v.d), busy[v.d], 0);
    endtask

    // Scoreboard: every reported event must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [1:0] got;
        int qn;
        for (int d = 0; d < 2; d++) begin
            if (valid[d] === 1'b1 || err_c[d] === 1'b1 || err_t[d] === 1'b1) begin
                evt_cyc[d] = cyc;
                if (valid[d]) got = K_VALID;
                else if (err_c[d]) got = K_CKSUM;
                else got = K_TIMEOUT;
                qn = (d == 0) ? q0.size() : q1.size();
                if (qn == 0) begin
                    chk($sformatf("d%0d_unexpected_event", d), got, K_NONE);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    chk($sformatf("d%0d_kind", d), got, e.kind);
                    chk($sformatf("d%0d_frame", d), frame[d], e.frame);
                    chk($sformatf("d%0d_hum", d), hum[d], e.hum);
                    chk($sformatf("d%0d_temp", d), temp[d], e.temp);
                    chk($sformatf("d%0d_th", d), th[d], e.th);
                    chk($sformatf("d%0d_tl", d), tl[d], e.tl);
                    if (e.kind == K_TIMEOUT) chk($sformatf("d%0d_timeout_busy", d), busy[d], 0);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        rst_n = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        sens[0] = 1'b1;  sens[1] = 1'b1;
        evt_cyc[0] = 0;  evt_cyc[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "rst_hold");
        chk_zero(1, "rst_hold");
        rst_n = 1'b1;
        wait_cyc(2);
        chk_zero(0, "post_rst");
        chk_zero(1, "post_rst");

        //           d  data            h0  h1  bits kind       frame            hum     temp     TH    TL
        vecs[0] = mk(0, 40'h3700190555, 26, 70, 40, K_VALID,   40'h3700190555, 16'd550, 16'd255, 1'b0, 1'b0);
        vecs[1] = mk(0, 40'h3700190556, 26, 70, 40, K_CKSUM,   40'h3700190555, 16'd550, 16'd255, 1'b0, 1'b0);
        vecs[2] = mk(0, 40'h3700190555, 26, 70, 10, K_TIMEOUT, 40'h3700190555, 16'd550, 16'd255, 1'b0, 1'b0);
        vecs[3] = mk(0, 40'h28050A0037, 40, 41, 40, K_VALID,   40'h28050A0037, 16'd405, 16'd100, 1'b0, 1'b1);
        vecs[4] = mk(0, 40'h28050B0038, 26, 70, 40, K_VALID,   40'h28050B0038, 16'd405, 16'd110, 1'b0, 1'b1);
        vecs[5] = mk(0, 40'h28050B5189, 26, 70, 40, K_VALID,   40'h28050B5189, 16'd405, 16'd111, 1'b0, 1'b0);
        vecs[6] = mk(1, 40'h028C806573, 26, 70, 40, K_VALID,   40'h028C806573, 16'd652, 16'hFF9B, 1'b0, 1'b1);
        vecs[7] = mk(1, 40'h0200012C2F, 26, 70, 40, K_VALID,   40'h0200012C2F, 16'd512, 16'd300, 1'b1, 1'b0);
        vecs[8] = mk(1, 40'h020001272A, 26, 70, 40, K_VALID,   40'h020001272A, 16'd512, 16'd295, 1'b1, 1'b0);
        vecs[9] = mk(1, 40'h0200012124, 26, 70, 40, K_VALID,   40'h0200012124, 16'd512, 16'd289, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of the bit stream: outputs clear on the next
        // edge and the remainder of the frame must not produce an event.
        fork
            send_frame(1, 40'h0200012C2F, 26, 70, 40);
            begin
                wait_cyc(700);
                rst_n = 1'b0;
                wait_cyc(1);
                chk_zero(1, "mid_rst");
                chk_zero(0, "mid_rst");
                rst_n = 1'b1;
            end
        join
        wait_cyc(20);
        chk("d1_frame_after_mid_rst", frame[1], 0);
        chk("d1_busy_after_mid_rst", busy[1], 0);

        // Recovery after reset: alarms start from cleared state.
        run_vec(vecs[7]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dht_rx_ctrl.md
Name: dht_rx_ctrl

Overview:
Parametrised single-wire humidity/temperature sensor controller, successor to the fixed DHT11 receiver.
- Drives the host start pulse itself and times every phase with a microsecond prescaler.
- Decodes the 40-bit frame, checks the checksum, and supports DHT11 and DHT22 formats.
- Publishes scaled readings plus TH/TL alarm flags with hysteresis. Sits between the bidirectional sensor pad (open-drain) and the display/alarm logic.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; US_DIV = CLK_HZ/1_000_000 cycles per microsecond tick (min 1)
MODE, 0, 0 = DHT11 frame format, 1 = DHT22 frame format
START_US, 18000, host low-pulse length in microseconds
BIT_THR_US, 40, data-bit high time strictly above this decodes as 1
TIMEOUT_US, 200, maximum duration of any sensor-driven phase
T_HI, 300, high alarm threshold, signed tenths of a degree C
T_LO, 100, low alarm threshold, signed tenths of a degree C
HYST, 10, alarm hysteresis, tenths of a degree C

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle read request; ignored while busy
dht_i  in  1  sensor line as read from the pad, asynchronous
dht_oe  out  1  1 = pull line low, 0 = release (pad pull-up)
busy  out  1  high from accepted start until return to IDLE
frame  out  40  last good frame, byte0 (first received) in [39:32]
hum_x10  out  16  humidity in tenths of a percent, unsigned
temp_x10  out  16  temperature in tenths of a degree C, two's complement
valid  out  1  one-cycle pulse when frame/hum_x10/temp_x10 update
err_cksum  out  1  one-cycle pulse on checksum mismatch
err_timeout  out  1  one-cycle pulse on phase timeout
TH  out  1  high alarm
TL  out  1  low alarm

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, state IDLE, prescaler and counters cleared. Applies mid-frame; dht_oe releases on the next edge.
- Input path: dht_i goes through a 2-flop synchroniser. Edges are detected on the synchronised value, so decode latency is 2 cycles from pin to state machine.
- us tick: prescaler pulses once every US_DIV cycles. The phase counter counts ticks, saturates, and clears on every state change.
- State machine:
  - IDLE: when start=1, go to START_LOW and set busy=1.
  - START_LOW: dht_oe=1 for START_US ticks, then go to RELEASE.
  - RELEASE: dht_oe=0; on a falling line edge go to RESP_LOW.
  - RESP_LOW: on a rising edge go to RESP_HIGH.
  - RESP_HIGH: on a falling edge go to BIT_LOW.
  - BIT_LOW: on a rising edge go to BIT_HIGH.
  - BIT_HIGH: on a falling edge, shift in bit = (count > BIT_THR_US), MSB first, and increment the bit index. Go to BIT_LOW, or to CHECK after bit 39.
  - CHECK: evaluate for 1 cycle, then DONE. DONE: clear busy and return to IDLE.
- Timeout: in RELEASE, RESP_*, and BIT_* states, a count reaching TIMEOUT_US pulses err_timeout and forces IDLE. busy drops in the same cycle. frame and the alarms are unchanged.
- Checksum: (b0+b1+b2+b3) mod 256 must equal b4.
  - Mismatch: pulse err_cksum and hold all data outputs.
  - Match: in the CHECK cycle, register frame, hum_x10, and temp_x10 and pulse valid. TH and TL update in the same cycle.
- Scaling, MODE=0:
  - hum_x10 = b0*10 + b1.
  - temp_x10 = b2*10 + b3[3:0], positive only.
- Scaling, MODE=1:
  - hum_x10 = {b0,b1}.
  - temp_x10 = {b2[7]} ? -{b2[6:0],b3} : {b2[6:0],b3}.
- Alarms (signed compare; evaluated only on valid frames):
  - TH sets when temp_x10 >= T_HI and clears when temp_x10 < T_HI-HYST.
  - TL sets when temp_x10 <= T_LO and clears when temp_x10 > T_LO+HYST.
  - Otherwise both hold.
- Edge cases:
  - start during busy is dropped with no queueing.
  - start in the DONE cycle is ignored.
  - A glitch shorter than 1 cycle after synchronisation is invisible.
  - A bit high time exactly equal to BIT_THR_US decodes as 0.

Test Plan:
Use CLK_HZ=1_000_000 (1 tick per cycle) and START_US=20 throughout.
1. Hold rst_n=0 for 3 cycles, then release -> all outputs 0, dht_oe=0, busy=0. Pulse start -> dht_oe=1 for exactly 20 cycles.
2. MODE=0, frame 0x37 00 19 05 55, with 0-bit high time 26 and 1-bit high time 70 -> valid pulses once, frame=0x3700190555, hum_x10=550, temp_x10=255, TH=0, TL=0, busy=0.
3. Same frame with checksum 0x56 -> err_cksum pulses once, valid stays 0, and frame/hum_x10/temp_x10 keep their prior values.
4. Sensor line stays high after 10 bits -> err_timeout pulses 200 cycles after the last edge and busy=0. A new start then succeeds.
5. MODE=1, frame 0x02 8C 80 65 73 -> hum_x10=652, temp_x10=-101 (0xFF9B), TL=1, TH=0.
6. Hysteresis (MODE=1): successive frames with temp 300, 295, 289 -> TH 1, 1, 0. Also assert rst_n=0 mid-bit-stream -> outputs 0 next edge, and no valid pulse follows.
